ball_motion_engine: RTL and testbench

- Upstream neighbour of the top-level VGA renderer.
- Owns the bouncing-ball state: position, direction and speed, advanced once per frame on a frame tick taken from the sync generator's (x==0, y==0) point.
- Publishes ball_x/ball_y atomically, so the renderer's per-pixel distance compare never sees a half-updated coordinate pair.
- Replaces the ad-hoc ball registers in the renderer.

---
 rtl/ball_motion_engine.sv | 136 +++++++++++++
 tb/tb_ball_motion_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_engine.sv
// Bouncing-ball position/direction engine, advanced once per frame tick and committed atomically.
// Optional macro SPEED_RAMP_EN: speed rises by one every RAMP_BOUNCES bounces, up to MAX_SPEED.
module ball_motion_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 20,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 2,
  parameter int INIT_X       = 320,
  parameter int INIT_Y       = 240,
  parameter int RAMP_BOUNCES = 8,
  parameter int MAX_SPEED    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] speed,
  output logic       update_done,
  output logic       bounce,
  output logic       tick_overrun
);

  localparam logic [10:0] POS_MIN = 11'(BALL_SIZE);
  localparam logic [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

  state_t     state, state_next;
  logic [2:0] step_x, step_y;
  logic [9:0] next_x, next_y;
  logic       next_dir_x, next_dir_y;
  logic       hit_x, hit_y;
  logic [11:0] calc_x, calc_y;

`ifdef SPEED_RAMP_EN
  logic [3:0] bounce_cnt;
  assign step_x = speed;
  assign step_y = speed;
`else
  assign speed  = 3'(SPEED_X);
  assign step_x = 3'(SPEED_X);
  assign step_y = 3'(SPEED_Y);
`endif

  // Returns {hit, new_dir, new_pos}; the left/top test runs before subtracting so nothing underflows.
  function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                            input logic [2:0] step, input logic [10:0] pos_max);
    logic [10:0] sum;
    logic [10:0] low_lim;
    sum     = {1'b0, pos} + {8'b0, step};
    low_lim = POS_MIN + {8'b0, step};
    if (dir) begin
      if (sum >= pos_max) axis_step = {1'b1, 1'b0, pos_max[9:0]};
      else                axis_step = {1'b0, 1'b1, sum[9:0]};
    end else begin
      if ({1'b0, pos} <= low_lim) axis_step = {1'b1, 1'b1, POS_MIN[9:0]};
      else                        axis_step = {1'b0, 1'b0, pos - {7'b0, step}};
    end
  endfunction

  assign calc_x = axis_step(ball_x, dir_x, step_x, X_MAX);
  assign calc_y = axis_step(ball_y, dir_y, step_y, Y_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_tick && !pause) state_next = STEP_X;
      STEP_X:  state_next = STEP_Y;
      STEP_Y:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shadow registers keep the published pair stable until both axes are ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x       <= 10'(INIT_X);
      ball_y       <= 10'(INIT_Y);
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      next_x       <= 10'(INIT_X);
      next_y       <= 10'(INIT_Y);
      next_dir_x   <= 1'b1;
      next_dir_y   <= 1'b1;
      hit_x        <= 1'b0;
      hit_y        <= 1'b0;
      update_done  <= 1'b0;
      bounce       <= 1'b0;
      tick_overrun <= 1'b0;
`ifdef SPEED_RAMP_EN
      speed        <= 3'(SPEED_X);
      bounce_cnt   <= 4'd0;
`endif
    end else begin
      update_done <= 1'b0;
      bounce      <= 1'b0;
      if (frame_tick && state != IDLE) tick_overrun <= 1'b1;
      case (state)
        STEP_X: {hit_x, next_dir_x, next_x} <= calc_x;
        STEP_Y: {hit_y, next_dir_y, next_y} <= calc_y;
        COMMIT: begin
          ball_x      <= next_x;
          ball_y      <= next_y;
          dir_x       <= next_dir_x;
          dir_y       <= next_dir_y;
          update_done <= 1'b1;
          bounce      <= hit_x | hit_y;
`ifdef SPEED_RAMP_EN
          if (hit_x | hit_y) begin
            if (bounce_cnt == 4'(RAMP_BOUNCES - 1)) begin
              bounce_cnt <= 4'd0;
              if (speed < 3'(MAX_SPEED)) speed <= speed + 3'd1;
            end else begin
              bounce_cnt <= bounce_cnt + 4'd1;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed self-checking bench for ball_motion_engine (default build; ramp checks when SPEED_RAMP_EN is defined).
module tb_ball_motion_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y;
  logic [2:0] speed;
  logic       update_done, bounce, tick_overrun;

  int compared = 0;
  int mismatched = 0;

  ball_motion_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
    .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .speed(speed), .update_done(update_done), .bounce(bounce),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // One frame tick, then wait (bounded) for the commit; returns at the negedge where update_done is high.
  task automatic applyStimulus();
    logic ok;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (update_done) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) checkOutput("tick_timeout", 32'(ok), 32'd1);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (update_done) pulses++;
    end
  endtask

  int pulses;

  initial begin
    // reset values
    do_reset();
    @(negedge clk);
    checkOutput("rst_x", 32'(ball_x), 32'd320);
    checkOutput("rst_y", 32'(ball_y), 32'd240);
    checkOutput("rst_dir", 32'({dir_x, dir_y}), 32'd3);
    checkOutput("rst_speed", 32'(speed), 32'd2);
    checkOutput("rst_done", 32'(update_done), 32'd0);
    checkOutput("rst_ovr", 32'(tick_overrun), 32'd0);

    // single tick: three-edge latency, one-cycle done pulse
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
    checkOutput("lat1_x", 32'(ball_x), 32'd320);
    checkOutput("lat1_done", 32'(update_done), 32'd0);
    @(negedge clk);
    checkOutput("lat2_y", 32'(ball_y), 32'd240);
    checkOutput("lat2_done", 32'(update_done), 32'd0);
    @(negedge clk);
    checkOutput("lat3_x", 32'(ball_x), 32'd322);
    checkOutput("lat3_y", 32'(ball_y), 32'd242);
    checkOutput("lat3_done", 32'(update_done), 32'd1);
    checkOutput("lat3_bounce", 32'(bounce), 32'd0);
    @(negedge clk);
    checkOutput("lat4_done", 32'(update_done), 32'd0);

    // back-to-back ticks: one update, sticky overrun
    do_reset();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    count_pulses(10, pulses);
    checkOutput("ovr_pulses", 32'(pulses), 32'd1);
    checkOutput("ovr_x", 32'(ball_x), 32'd322);
    checkOutput("ovr_y", 32'(ball_y), 32'd242);
    checkOutput("ovr_flag", 32'(tick_overrun), 32'd1);
    applyStimulus();
    checkOutput("ovr_next_x", 32'(ball_x), 32'd324);
    checkOutput("ovr_sticky", 32'(tick_overrun), 32'd1);
    do_reset();
    checkOutput("ovr_clear", 32'(tick_overrun), 32'd0);

    // pause discards ticks without flagging
    pause = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      int p;
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      count_pulses(5, p);
      pulses += p;
    end
    checkOutput("pause_pulses", 32'(pulses), 32'd0);
    checkOutput("pause_x", 32'(ball_x), 32'd320);
    checkOutput("pause_y", 32'(ball_y), 32'd240);
    checkOutput("pause_ovr", 32'(tick_overrun), 32'd0);
    pause = 1'b0;
    applyStimulus();
    checkOutput("unpause_x", 32'(ball_x), 32'd322);
    checkOutput("unpause_y", 32'(ball_y), 32'd242);

    // reset while in STEP_Y aborts the update
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) reset = 1'b1;
    #1;
    checkOutput("abort_x", 32'(ball_x), 32'd320);
    checkOutput("abort_y", 32'(ball_y), 32'd240);
    checkOutput("abort_dir", 32'({dir_x, dir_y}), 32'd3);
    checkOutput("abort_speed", 32'(speed), 32'd2);
    @(negedge clk) reset = 1'b0;
    count_pulses(6, pulses);
    checkOutput("abort_pulses", 32'(pulses), 32'd0);
    checkOutput("abort_hold_x", 32'(ball_x), 32'd320);

    // long run: bottom wall at tick 110, right wall at tick 150
    for (int t = 1; t <= 151; t++) begin
      applyStimulus();
      if (t == 109) begin
        checkOutput("t109_y", 32'(ball_y), 32'd458);
        checkOutput("t109_bounce", 32'(bounce), 32'd0);
      end
      if (t == 110) begin
        checkOutput("t110_y", 32'(ball_y), 32'd460);
        checkOutput("t110_diry", 32'(dir_y), 32'd0);
        checkOutput("t110_bounce", 32'(bounce), 32'd1);
        checkOutput("t110_x", 32'(ball_x), 32'd540);
      end
      if (t == 150) begin
        checkOutput("t150_x", 32'(ball_x), 32'd620);
        checkOutput("t150_dirx", 32'(dir_x), 32'd0);
        checkOutput("t150_bounce", 32'(bounce), 32'd1);
        checkOutput("t150_y", 32'(ball_y), 32'd380);
      end
      if (t == 151) begin
        checkOutput("t151_x", 32'(ball_x), 32'd618);
        checkOutput("t151_bounce", 32'(bounce), 32'd0);
      end
    end

`ifdef SPEED_RAMP_EN
    begin
      int bounces, guard, prev_x, dx;
      do_reset();
      bounces = 0;
      guard = 0;
      while (bounces < 8 && guard < 4000) begin
        applyStimulus();
        if (bounce) bounces++;
        guard++;
      end
      checkOutput("ramp_bounces", 32'(bounces), 32'd8);
      checkOutput("ramp_speed3", 32'(speed), 32'd3);
      prev_x = int'(ball_x);
      applyStimulus();
      dx = int'(ball_x) - prev_x;
      if (dx < 0) dx = -dx;
      if (!bounce) checkOutput("ramp_step3", 32'(dx), 32'd3);
      guard = 0;
      while (speed < 3'd6 && guard < 8000) begin
        applyStimulus();
        guard++;
      end
      checkOutput("ramp_speed6", 32'(speed), 32'd6);
      bounces = 0;
      guard = 0;
      while (bounces < 10 && guard < 3000) begin
        applyStimulus();
        if (bounce) bounces++;
        guard++;
      end
      checkOutput("ramp_sat", 32'(speed), 32'd6);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
